// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for two-player pong (scores, ball freeze, delay timer).
// Every output except gra_still is registered, so there is no combinational path from pts to the scores.
module pong_game_ctrl #(
    parameter logic [7:0]  WIN_SCORE   = 8'h07,
    parameter int unsigned DELAY_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic [3:0] btn,
    input  logic       pts_1,
    input  logic       pts_2,
    output logic       gra_still,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic [1:0] game_state,
    output logic       winner,
    output logic       point_strobe
);
    typedef enum logic [1:0] {NEWGAME = 2'b00, PLAY = 2'b01, NEWBALL = 2'b10, OVER = 2'b11} state_t;

    localparam logic [7:0] DELAY = 8'(DELAY_TICKS);

    state_t     state, state_n;
    logic [7:0] timer, timer_n, score1_n, score2_n, inc1, inc2;
    logic       winner_n, strobe_n, btn_any_d, press, timer_done;

    // 8'h99 saturates rather than wrapping to 8'h00
    function automatic logic [7:0] bcd_inc(input logic [7:0] x);
        logic [3:0] tens;
        tens = x[7:4] + 4'd1;
        if (x == 8'h99) return x;
        if (x[3:0] == 4'd9) return {tens, 4'd0};
        return {x[7:4], x[3:0] + 4'd1};
    endfunction

    assign press      = (|btn) & ~btn_any_d;
    assign timer_done = timer == 8'd0;
    assign inc1       = bcd_inc(score1);
    assign inc2       = bcd_inc(score2);
    assign gra_still  = state != PLAY;
    assign game_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= NEWGAME;
            score1       <= 8'h00;
            score2       <= 8'h00;
            timer        <= 8'd0;
            winner       <= 1'b0;
            point_strobe <= 1'b0;
            btn_any_d    <= 1'b0;
        end else begin
            state        <= state_n;
            score1       <= score1_n;
            score2       <= score2_n;
            timer        <= timer_n;
            winner       <= winner_n;
            point_strobe <= strobe_n;
            btn_any_d    <= |btn;
        end
    end

    always_comb begin
        state_n  = state;
        score1_n = score1;
        score2_n = score2;
        timer_n  = (refresh_tick && !timer_done) ? timer - 8'd1 : timer;
        winner_n = winner;
        strobe_n = 1'b0;
        case (state)
            NEWGAME: if (press) begin
                state_n  = PLAY;
                score1_n = 8'h00;
                score2_n = 8'h00;
            end
            // player 1 wins ties between simultaneous pts inputs
            PLAY: if (pts_1) begin
                score1_n = inc1;
                strobe_n = 1'b1;
                timer_n  = DELAY;
                winner_n = 1'b0;
                state_n  = (inc1 == WIN_SCORE) ? OVER : NEWBALL;
            end else if (pts_2) begin
                score2_n = inc2;
                strobe_n = 1'b1;
                timer_n  = DELAY;
                winner_n = inc2 == WIN_SCORE;
                state_n  = (inc2 == WIN_SCORE) ? OVER : NEWBALL;
            end
            NEWBALL: if (timer_done && press) state_n = PLAY;
            OVER: if (timer_done) begin
                state_n  = NEWGAME;
                winner_n = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: two DUT instances (win at 7 and at 12, 4-tick delay) share directed and random stimulus.
// A decimal-integer game model predicts every output each cycle; literal checks pin key moments.
module tb_pong_game_ctrl;
    logic       clk = 1'b0, reset = 1'b1, refresh_tick = 1'b0, pts_1 = 1'b0, pts_2 = 1'b0;
    logic [3:0] btn = 4'd0;
    logic       a_still, a_win, a_stb, b_still, b_win, b_stb;
    logic [7:0] a_s1, a_s2, b_s1, b_s2;
    logic [1:0] a_st, b_st;
    int         n_cmp = 0, n_bad = 0;
    bit         armed = 1'b0;

    typedef struct packed {
        int st;
        int s1;
        int s2;
        int t;
        bit w;
        bit strobe;
        bit prev;
    } mdl_t;

    mdl_t ma = '0, mb = '0;

    pong_game_ctrl #(.WIN_SCORE(8'h07), .DELAY_TICKS(4)) ua (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn(btn), .pts_1(pts_1), .pts_2(pts_2),
        .gra_still(a_still), .score1(a_s1), .score2(a_s2), .game_state(a_st), .winner(a_win), .point_strobe(a_stb));

    pong_game_ctrl #(.WIN_SCORE(8'h12), .DELAY_TICKS(4)) ub (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .btn(btn), .pts_1(pts_1), .pts_2(pts_2),
        .gra_still(b_still), .score1(b_s1), .score2(b_s2), .game_state(b_st), .winner(b_win), .point_strobe(b_stb));

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        return 8'((n / 10) * 16 + n % 10);
    endfunction

    // Game rules in plain integers: 0=new game, 1=play, 2=new ball, 3=over
    function automatic mdl_t step(input mdl_t m, input logic [3:0] b, input logic p1, input logic p2,
                                  input logic rt, input logic rst, input int win);
        mdl_t n;
        bit press;
        n = m;
        if (rst) return '0;
        press    = (b != 0) && !m.prev;
        n.prev   = b != 0;
        n.strobe = 0;
        if (rt && m.t > 0) n.t = m.t - 1;
        if (m.st == 0 && press) begin
            n.st = 1; n.s1 = 0; n.s2 = 0;
        end else if (m.st == 1 && (p1 || p2)) begin
            n.strobe = 1;
            n.t = 4;
            if (p1) n.s1 = (m.s1 < 99) ? m.s1 + 1 : 99;
            else n.s2 = (m.s2 < 99) ? m.s2 + 1 : 99;
            n.w  = !p1 && n.s2 == win;
            n.st = ((p1 ? n.s1 : n.s2) == win) ? 3 : 2;
        end else if (m.st == 2 && m.t == 0 && press) begin
            n.st = 1;
        end else if (m.st == 3 && m.t == 0) begin
            n.st = 0; n.w = 0;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string p, input logic still, input logic [7:0] s1, input logic [7:0] s2,
                             input logic [1:0] st, input logic w, input logic stb, input mdl_t m);
        check({p, "_state"}, 8'(st), 8'(m.st));
        check({p, "_gra_still"}, 8'(still), 8'(m.st != 1));
        check({p, "_score1"}, s1, bcd(m.s1));
        check({p, "_score2"}, s2, bcd(m.s2));
        check({p, "_winner"}, 8'(w), 8'(m.w));
        check({p, "_strobe"}, 8'(stb), 8'(m.strobe));
    endtask

    always @(posedge clk) begin
        ma = step(ma, btn, pts_1, pts_2, refresh_tick, reset, 7);
        mb = step(mb, btn, pts_1, pts_2, refresh_tick, reset, 12);
        if (reset) armed = 1'b1;
    end

    always @(negedge clk) if (armed) begin
        check_all("A", a_still, a_s1, a_s2, a_st, a_win, a_stb, ma);
        check_all("B", b_still, b_s1, b_s2, b_st, b_win, b_stb, mb);
    end

    task automatic cyc(input logic [3:0] b, input logic p1, input logic p2, input logic rt);
        btn = b; pts_1 = p1; pts_2 = p2; refresh_tick = rt;
        @(negedge clk);
    endtask

    task automatic to_play();
        repeat (4) cyc(4'd0, 0, 0, 1);
        cyc(4'd0, 0, 0, 0);
        cyc(4'd1, 0, 0, 0);
    endtask

    initial begin
        cyc(4'd0, 0, 0, 0);
        cyc(4'd0, 0, 0, 0);
        reset = 1'b0;
        check("rst_state", 8'(a_st), 8'h00);
        check("rst_still", 8'(a_still), 8'h01);
        check("rst_scores", {a_s1[3:0], a_s2[3:0]}, 8'h00);
        cyc(4'd1, 0, 0, 0);
        check("start_state", 8'(a_st), 8'h01);
        check("start_still", 8'(a_still), 8'h00);
        check("start_s1", a_s1, 8'h00);
        // held button and held pts_1 across the point
        cyc(4'd1, 1, 0, 0);
        check("pt1_s1", a_s1, 8'h01);
        check("pt1_strobe", 8'(a_stb), 8'h01);
        check("pt1_state", 8'(a_st), 8'h02);
        repeat (4) cyc(4'd1, 1, 0, 0);
        check("pt1_once", a_s1, 8'h01);
        check("pt1_strobe_off", 8'(a_stb), 8'h00);
        repeat (4) cyc(4'd1, 0, 0, 1);
        cyc(4'd1, 0, 0, 0);
        check("held_btn_stays", 8'(a_st), 8'h02);
        cyc(4'd0, 0, 0, 0);
        cyc(4'd1, 0, 0, 0);
        check("repress_play", 8'(a_st), 8'h01);
        // early press discarded
        cyc(4'd0, 1, 0, 0);
        check("pt2_s1", a_s1, 8'h02);
        repeat (2) cyc(4'd0, 0, 0, 1);
        cyc(4'd4, 0, 0, 0);
        check("early_press", 8'(a_st), 8'h02);
        cyc(4'd0, 0, 0, 1);
        cyc(4'd0, 0, 0, 1);
        cyc(4'd4, 0, 0, 0);
        check("late_press", 8'(a_st), 8'h01);
        // simultaneous points
        cyc(4'd0, 1, 1, 0);
        check("both_s1", a_s1, 8'h03);
        check("both_s2", a_s2, 8'h00);
        to_play();
        // player 2 wins
        repeat (6) begin
            cyc(4'd0, 0, 1, 0);
            to_play();
        end
        check("p2_six", a_s2, 8'h06);
        cyc(4'd0, 0, 1, 0);
        check("win_s2", a_s2, 8'h07);
        check("win_state", 8'(a_st), 8'h03);
        check("win_winner", 8'(a_win), 8'h01);
        repeat (4) cyc(4'd1, 0, 0, 1);
        check("over_hold", 8'(a_st), 8'h03);
        cyc(4'd0, 0, 0, 0);
        check("over_done", 8'(a_st), 8'h00);
        check("over_winner", 8'(a_win), 8'h00);
        check("over_s2", a_s2, 8'h07);
        cyc(4'd1, 0, 0, 0);
        check("newgame_state", 8'(a_st), 8'h01);
        check("newgame_scores", {a_s1[3:0], a_s2[3:0]}, 8'h00);
        // BCD carry on the win-at-12 instance, then reset mid-timer
        reset = 1'b1;
        cyc(4'd0, 0, 0, 0);
        reset = 1'b0;
        cyc(4'd1, 0, 0, 0);
        repeat (9) begin
            cyc(4'd0, 1, 0, 0);
            to_play();
        end
        check("b_nine", b_s1, 8'h09);
        cyc(4'd0, 1, 0, 0);
        check("b_carry", b_s1, 8'h10);
        check("b_carry_state", 8'(b_st), 8'h02);
        cyc(4'd0, 0, 0, 1);
        reset = 1'b1;
        cyc(4'd0, 0, 0, 0);
        reset = 1'b0;
        check("b_rst_state", 8'(b_st), 8'h00);
        check("b_rst_s1", b_s1, 8'h00);
        check("b_rst_still", 8'(b_still), 8'h01);
        // random play
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] b;
            logic       p1, p2;
            b  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : btn;
            p1 = ($urandom_range(0, 5) == 0) ? 1'($urandom) : pts_1;
            p2 = ($urandom_range(0, 5) == 0) ? 1'($urandom) : pts_2;
            reset = $urandom_range(0, 999) == 0;
            cyc(b, p1, p2, $urandom_range(0, 2) == 0);
        end
        reset = 1'b0;
        cyc(4'd0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
